// File: rtl/sms_trigger_driver.sv
// ---------------------------------------------------------------------------
// sms_trigger_driver
//
// Drives the set (p) and reset (q) inputs of an external flip-flop card with
// fixed-width pulses. After each pulse it waits a recovery gap and then checks
// the card's fed-back output against the intended value.
//
// Parameters
//   PULSE_W  drive-pulse width in clk cycles (1..15)
//   GAP_W    low recovery gap after each pulse in clk cycles (1..15)
//
// Ports
//   clk         single clock, rising edge
//   rst_n       asynchronous active-low reset
//   req_set     request a set pulse on p
//   req_reset   request a reset pulse on q
//   req_toggle  request a pulse that flips the card, direction chosen from fb_c
//   level_en    requested steady level for l
//   fb_c        card's c output, fed back for checking
//   p, q        registered set / reset drive pulses (never high together)
//   l           registered copy of level_en
//   busy        high while an operation is in progress
//   done        one-cycle strobe at the end of an operation
//   err         one-cycle strobe on a request conflict or feedback mismatch
// ---------------------------------------------------------------------------
module sms_trigger_driver #(
  parameter int unsigned PULSE_W = 2,
  parameter int unsigned GAP_W   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_set,
  input  logic req_reset,
  input  logic req_toggle,
  input  logic level_en,
  input  logic fb_c,
  output logic p,
  output logic q,
  output logic l,
  output logic busy,
  output logic done,
  output logic err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    CHECK = 2'd3
  } state_e;

  localparam logic [3:0] PULSE_CNT = 4'(PULSE_W);
  localparam logic [3:0] GAP_CNT   = 4'(GAP_W);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       target_q, target_d;
  logic       p_drv_q, p_drv_d;
  logic       q_drv_q, q_drv_d;
  logic       conflict_q, conflict_d;
  logic       l_q;

  // State register: every register clears asynchronously, so p/q drop the
  // moment rst_n falls, truncating any pulse in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      target_q   <= 1'b0;
      p_drv_q    <= 1'b0;
      q_drv_q    <= 1'b0;
      conflict_q <= 1'b0;
      l_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      target_q   <= target_d;
      p_drv_q    <= p_drv_d;
      q_drv_q    <= q_drv_d;
      conflict_q <= conflict_d;
      l_q        <= level_en;
    end
  end

  // Next-state logic. The one counter times both PULSE and GAP: it is loaded
  // on entry to each and the state moves on when it reaches 1.
  always_comb begin
    logic start;
    start      = 1'b0;
    state_d    = state_q;
    cnt_d      = cnt_q;
    target_d   = target_q;
    conflict_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = 4'd0;
        if (req_set && req_reset) begin
          conflict_d = 1'b1;
        end else if (req_set) begin
          target_d = 1'b1;
          start    = 1'b1;
        end else if (req_reset) begin
          target_d = 1'b0;
          start    = 1'b1;
        end else if (req_toggle) begin
          target_d = ~fb_c;
          start    = 1'b1;
        end
        if (start) begin
          state_d = PULSE;
          cnt_d   = PULSE_CNT;
        end
      end
      PULSE: begin
        if (cnt_q <= 4'd1) begin
          state_d = GAP;
          cnt_d   = GAP_CNT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      GAP: begin
        if (cnt_q <= 4'd1) begin
          state_d = CHECK;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      CHECK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    // Drive registers are computed from the next state so p/q line up
    // exactly with the PULSE state while still coming straight from flops.
    p_drv_d = (state_d == PULSE) &&  target_d;
    q_drv_d = (state_d == PULSE) && !target_d;
  end

  // Outputs. err combines the registered conflict strobe with the live
  // feedback comparison made during CHECK.
  always_comb begin
    p    = p_drv_q;
    q    = q_drv_q;
    l    = l_q;
    busy = (state_q != IDLE);
    done = (state_q == CHECK);
    err  = conflict_q | ((state_q == CHECK) && (fb_c != target_q));
  end

endmodule
